mu0_sequencer: RTL and testbench

MU0_SEQUENCER -- requirements
Module: mu0_sequencer

---
 rtl/mu0_pkg.sv | 29 ++
 rtl/mu0_instr_counter.sv | 24 ++
 rtl/mu0_sequencer.sv | 113 +++++++++++
 tb/tb_mu0_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mu0_pkg.sv
// Shared MU0 definitions: sequencer state encoding and opcode constants
// that the decode logic also uses.
package mu0_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC1 = 3'd2,
        ST_EXEC2 = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam int OPC_W = 4;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_STA = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h3;
    localparam logic [OPC_W-1:0] OP_JMP = 4'h4;
    localparam logic [OPC_W-1:0] OP_JGE = 4'h5;
    localparam logic [OPC_W-1:0] OP_JNE = 4'h6;
    localparam logic [OPC_W-1:0] OP_STP = 4'h7;

    // Memory-operand instructions need the second execute cycle.
    function automatic logic op_needs_extra(input logic [OPC_W-1:0] op);
        return (op == OP_LDA) || (op == OP_STA) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/mu0_instr_counter.sv
// Retired-instruction counter: CNT_W-bit enable counter, wraps naturally,
// asynchronous active-low clear.
module mu0_instr_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/mu0_sequencer.sv
// MU0 control sequencer: FETCH/EXEC1/EXEC2 phase generation, run/step/halt
// control, conditional-skip tracking and retired-instruction counting.
module mu0_sequencer
    import mu0_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_run,
    input  logic             i_step,
    input  logic             i_extra,
    input  logic             i_stp,
    input  logic             i_skip_set,
    output logic             o_fetch,
    output logic             o_exec1,
    output logic             o_exec2,
    output logic             o_ir_load,
    output logic             o_skipstatus,
    output logic             o_halted,
    output logic [CNT_W-1:0] o_instr_count
);

    state_e r_state;
    state_e w_state_nxt;
    logic   r_run_mode;
    logic   w_run_mode_nxt;
    logic   r_skip;
    logic   w_skip_nxt;
    logic   w_instr_end;
    logic   w_halt_entry;
    logic   w_cnt_en;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_IDLE;
            r_run_mode <= 1'b0;
            r_skip     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run_mode <= w_run_mode_nxt;
            r_skip     <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_run_mode_nxt = r_run_mode;
        w_skip_nxt     = r_skip;
        w_instr_end    = 1'b0;
        w_halt_entry   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_run) begin
                    w_state_nxt    = ST_FETCH;
                    w_run_mode_nxt = 1'b1;
                end else if (i_step) begin
                    w_state_nxt    = ST_FETCH;
                    w_run_mode_nxt = 1'b0;
                end
            end
            ST_FETCH: w_state_nxt = ST_EXEC1;
            ST_EXEC1: begin
                // A skipped STP falls through and retires like any other instruction.
                if (i_stp && !r_skip) begin
                    w_state_nxt  = ST_HALT;
                    w_halt_entry = 1'b1;
                end else if (i_extra) begin
                    w_state_nxt = ST_EXEC2;
                end else begin
                    w_instr_end = 1'b1;
                end
            end
            ST_EXEC2: w_instr_end = 1'b1;
            ST_HALT: begin
                if (i_run) begin
                    w_state_nxt    = ST_FETCH;
                    w_run_mode_nxt = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_instr_end) begin
            w_state_nxt = r_run_mode ? ST_FETCH : ST_IDLE;
            // A skip lasts exactly one instruction; no chaining.
            w_skip_nxt  = !r_skip && i_skip_set;
        end
        if (w_halt_entry) begin
            w_skip_nxt = 1'b0;
        end
    end

    assign w_cnt_en = (w_instr_end && !r_skip) || w_halt_entry;

    mu0_instr_counter #(
        .CNT_W (CNT_W)
    ) u_instr_counter (
        .i_clk   (i_clk),
        .i_rst_n (i_reset_n),
        .i_en    (w_cnt_en),
        .o_count (o_instr_count)
    );

    assign o_fetch      = (r_state == ST_FETCH);
    assign o_exec1      = (r_state == ST_EXEC1);
    assign o_exec2      = (r_state == ST_EXEC2);
    assign o_ir_load    = (r_state == ST_FETCH);
    assign o_halted     = (r_state == ST_HALT);
    assign o_skipstatus = r_skip;

endmodule

// File: tb/tb_mu0_sequencer.sv
// Self-checking bench for mu0_sequencer: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_mu0_sequencer;

    logic clk = 1'b0;
    logic rst_n, run, step, extra, stp, sset;
    logic fetch, exec1, exec2, ir_load, skip, halted;
    logic [15:0] cnt;
    logic f4, e14, e24, ir4, sk4, h4;
    logic [3:0] cnt4;

    int checks = 0;
    int errors = 0;

    // Reference model: instructions retired so far and whether the next one is skipped.
    int unsigned m_count = 0;
    bit          m_skip  = 1'b0;

    always #5 clk = ~clk;

    mu0_sequencer dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_run(run), .i_step(step),
        .i_extra(extra), .i_stp(stp), .i_skip_set(sset),
        .o_fetch(fetch), .o_exec1(exec1), .o_exec2(exec2), .o_ir_load(ir_load),
        .o_skipstatus(skip), .o_halted(halted), .o_instr_count(cnt)
    );

    mu0_sequencer #(.CNT_W(4)) dut4 (
        .i_clk(clk), .i_reset_n(rst_n), .i_run(run), .i_step(step),
        .i_extra(extra), .i_stp(stp), .i_skip_set(sset),
        .o_fetch(f4), .o_exec1(e14), .o_exec2(e24), .o_ir_load(ir4),
        .o_skipstatus(sk4), .o_halted(h4), .o_instr_count(cnt4)
    );

    // {fetch, exec1, exec2, halted, ir_load, skipstatus}
    function automatic logic [5:0] obs();
        return {fetch, exec1, exec2, halted, ir_load, skip};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1;
        tick();
        step = 1'b0;
    endtask

    // Runs one instruction starting in FETCH; run/step noise must be ignored.
    task automatic do_instr(input bit x, input bit s, input bit k, output bit h);
        logic [5:0] e;
        extra = x; stp = s; sset = k;
        run = 1'($urandom); step = 1'($urandom);
        checks++; e = {5'b10001, m_skip};
        if (obs() !== e) begin errors++; $display("FAIL fetch_phase got %b exp %b", obs(), e); end
        tick();
        checks++; e = {5'b01000, m_skip};
        if (obs() !== e) begin errors++; $display("FAIL exec1_phase got %b exp %b", obs(), e); end
        h = s && !m_skip;
        if (h) begin
            tick();
            m_count++;
            m_skip = 1'b0;
            checks++; e = 6'b000100;
            if (obs() !== e) begin errors++; $display("FAIL halt_entry got %b exp %b", obs(), e); end
        end else begin
            if (x) begin
                tick();
                checks++; e = {5'b00100, m_skip};
                if (obs() !== e) begin errors++; $display("FAIL exec2_phase got %b exp %b", obs(), e); end
            end
            tick();
            if (!m_skip) m_count++;
            m_skip = !m_skip && k;
        end
        run = 1'b0; step = 1'b0; extra = 1'b0; stp = 1'b0; sset = 1'b0;
        checks++;
        if (cnt !== m_count[15:0] || cnt4 !== m_count[3:0]) begin
            errors++;
            $display("FAIL instr_count got %0d/%0d exp %0d/%0d", cnt, cnt4, m_count[15:0], m_count[3:0]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 0; step = 0; extra = 0; stp = 0; sset = 0;
        #12;
        checks++;
        if (obs() !== 6'b0 || cnt !== 16'd0 || cnt4 !== 4'd0) begin
            errors++; $display("FAIL reset_state got %b cnt %0d exp 000000 cnt 0", obs(), cnt);
        end
        tick();
        rst_n = 1'b1;
        m_count = 0; m_skip = 0;
        tick();
        checks++;
        if (obs() !== 6'b0) begin errors++; $display("FAIL idle_after_reset got %b exp 000000", obs()); end
    endtask

    task automatic test_step();
        bit h;
        pulse_step();
        do_instr(1'b0, 1'b0, 1'b0, h);
        checks++;
        if (obs() !== 6'b0) begin errors++; $display("FAIL step_idle got %b exp 000000", obs()); end
        tick(); tick();
        checks++;
        if (obs() !== 6'b0 || cnt !== 16'd1) begin
            errors++; $display("FAIL step_stays_idle got %b cnt %0d exp 000000 cnt 1", obs(), cnt);
        end
        pulse_step();
        do_instr(1'b1, 1'b0, 1'b0, h);
        checks++;
        if (obs() !== 6'b0) begin errors++; $display("FAIL step_extra_idle got %b exp 000000", obs()); end
    endtask

    task automatic test_run_extra_halt();
        bit h;
        pulse_run();
        for (int i = 0; i < 3; i++) do_instr(1'b1, 1'b0, 1'b0, h);
        do_instr(1'b0, 1'b1, 1'b0, h);
        pulse_step();
        tick();
        checks++;
        if (obs() !== 6'b000100) begin errors++; $display("FAIL halt_ignores_step got %b exp 000100", obs()); end
        pulse_run();
        do_instr(1'b0, 1'b1, 1'b0, h);
    endtask

    task automatic test_skip();
        bit h;
        pulse_run();
        do_instr(1'b0, 1'b0, 1'b1, h);
        do_instr(1'b0, 1'b1, 1'b0, h);
        do_instr(1'b1, 1'b0, 1'b1, h);
        do_instr(1'b1, 1'b0, 1'b1, h);
        do_instr(1'b0, 1'b0, 1'b0, h);
        do_instr(1'b0, 1'b0, 1'b1, h);
        do_instr(1'b0, 1'b1, 1'b0, h);
        do_instr(1'b0, 1'b1, 1'b0, h);
    endtask

    task automatic test_random();
        bit h;
        pulse_run();
        for (int i = 0; i < 80; i++) begin
            do_instr(1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, h);
            if (h) pulse_run();
        end
        h = 1'b0;
        for (int i = 0; i < 3 && !h; i++) do_instr(1'b0, 1'b1, 1'b0, h);
    endtask

    task automatic test_reset_mid();
        bit h;
        logic [5:0] e;
        pulse_run();
        do_instr(1'b0, 1'b0, 1'b1, h);
        extra = 1'b1;
        tick();
        tick();
        checks++; e = {5'b00100, m_skip};
        if (obs() !== e) begin errors++; $display("FAIL pre_reset_exec2 got %b exp %b", obs(), e); end
        #2 rst_n = 1'b0;
        #1;
        m_count = 0; m_skip = 0;
        checks++;
        if (obs() !== 6'b0 || cnt !== 16'd0 || cnt4 !== 4'd0) begin
            errors++; $display("FAIL mid_reset got %b cnt %0d exp 000000 cnt 0", obs(), cnt);
        end
        extra = 1'b0;
        tick();
        rst_n = 1'b1;
        tick(); tick();
        checks++;
        if (obs() !== 6'b0 || cnt !== 16'd0) begin
            errors++; $display("FAIL idle_after_mid_reset got %b cnt %0d exp 000000 cnt 0", obs(), cnt);
        end
    endtask

    task automatic test_wrap();
        bit h;
        for (int i = 0; i < 16; i++) begin
            pulse_step();
            do_instr(1'($urandom), 1'b0, 1'b0, h);
        end
        checks++;
        if (cnt4 !== 4'd0 || cnt !== 16'd16) begin
            errors++; $display("FAIL count_wrap got %0d/%0d exp 0/16", cnt4, cnt);
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_run_extra_halt();
        test_skip();
        test_random();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
